// File: rtl/subtract_ctrl_if.sv
`timescale 1ns/1ps
`default_nettype none
// ============================================================================
// Module      : subtract_ctrl_if
// Description : Handshake bundle for subtract_ctrl. It carries the frame start
//               and status, the two FWFT input FIFO read ports and the output
//               FIFO write port. The slave modport is the controller's view and
//               the master modport is the view of whatever surrounds it.
// Revision    : 1.0 - initial release
// ============================================================================
interface subtract_ctrl_if;

    // Frame control and status
    logic       start;
    logic       busy;
    logic       done;

    // Base (background) FIFO, first-word-fall-through
    logic       base_empty;
    logic [7:0] base_dout;
    logic       base_rd_en;

    // Image FIFO, first-word-fall-through
    logic       img_empty;
    logic [7:0] img_dout;
    logic       img_rd_en;

    // Output FIFO
    logic       out_full;
    logic       out_wr_en;
    logic [7:0] out_din;

    // Environment side: feeds the FIFO heads and flags, observes the controller
    modport master (
        output start,
        output base_empty,
        output base_dout,
        output img_empty,
        output img_dout,
        output out_full,
        input  base_rd_en,
        input  img_rd_en,
        input  out_wr_en,
        input  out_din,
        input  busy,
        input  done
    );

    // Controller side
    modport slave (
        input  start,
        input  base_empty,
        input  base_dout,
        input  img_empty,
        input  img_dout,
        input  out_full,
        output base_rd_en,
        output img_rd_en,
        output out_wr_en,
        output out_din,
        output busy,
        output done
    );

endinterface : subtract_ctrl_if
`default_nettype wire

// File: rtl/subtract_ctrl.sv
`timescale 1ns/1ps
`default_nettype none
// ============================================================================
// Module      : subtract_ctrl
// Description : Background-subtraction frame controller. It pops one byte
//               from the base FIFO and one from the image FIFO in lock-step,
//               computes their 8-bit absolute difference into a one-entry
//               stage register, and writes the staged byte to the output
//               FIFO. It runs one pixel per cycle when nothing stalls and
//               stops after WIDTH*HEIGHT pixels.
//               Optional feature macro: SUBTRACT_THRESH_EN. When it is
//               defined, the stored byte becomes a binary mask
//               (absdiff > THRESHOLD ? 8'hFF : 8'h00).
// Revision    : 1.0 - initial release
// ============================================================================
module subtract_ctrl #(
    parameter int WIDTH     = 720,
    parameter int HEIGHT    = 540,
    parameter int THRESHOLD = 50
) (
    input  wire logic          clock,
    input  wire logic          reset,
    subtract_ctrl_if.slave     bus
);

    // ------------------------------------------------------------------------
    // Constants
    // ------------------------------------------------------------------------
    localparam int c_total = WIDTH * HEIGHT;
    // One extra count value, so the counter can reach c_total without wrapping
    localparam int c_cnt_w = $clog2(c_total + 1);
    localparam logic [c_cnt_w-1:0] c_last = c_cnt_w'(c_total);

    // Reject parameter sets that cannot describe a usable frame
    if (c_total < 1) begin : g_bad_frame
        $error("subtract_ctrl: WIDTH*HEIGHT must be at least 1");
    end

    // THRESHOLD is stored as a byte when the mask feature is enabled
    if ((THRESHOLD < 0) || (THRESHOLD > 255)) begin : g_bad_threshold
        $error("subtract_ctrl: THRESHOLD must fit in 8 bits");
    end

    // ------------------------------------------------------------------------
    // State encoding
    // ------------------------------------------------------------------------
    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        RUN   = 2'd1,
        DRAIN = 2'd2,
        DONE  = 2'd3
    } state_t;

    // ------------------------------------------------------------------------
    // Registers
    // ------------------------------------------------------------------------
    state_t               r_state;
    logic [c_cnt_w-1:0]   r_count;        // pixels popped in the current frame
    logic                 r_stage_valid;  // stage register holds an unwritten byte
    logic [7:0]           r_stage;        // result byte awaiting the output FIFO
    logic                 r_busy;
    logic                 r_done;

    // ------------------------------------------------------------------------
    // Combinational signals
    // ------------------------------------------------------------------------
    logic [7:0]           w_absdiff;
    logic [7:0]           w_result;
    logic                 w_pop;
    logic                 w_write;
    logic [c_cnt_w-1:0]   w_count_nxt;

    // Absolute difference; subtracting the smaller operand cannot overflow
    always_comb begin
        w_absdiff = 8'h00;
        if (bus.base_dout >= bus.img_dout) begin
            w_absdiff = bus.base_dout - bus.img_dout;
        end else begin
            w_absdiff = bus.img_dout - bus.base_dout;
        end
    end

`ifdef SUBTRACT_THRESH_EN
    localparam logic [7:0] c_thresh = 8'(THRESHOLD);

    // Binary motion mask: only a difference strictly above the threshold sets it
    always_comb begin
        w_result = 8'h00;
        if (w_absdiff > c_thresh) begin
            w_result = 8'hFF;
        end
    end
`else
    // Raw difference is passed straight through
    always_comb begin
        w_result = w_absdiff;
    end
`endif

    // A pop needs both input bytes and room in the stage register. The stage
    // has room when it is empty or when it is being written out this cycle.
    assign w_pop = (r_state == RUN)
                 & ~bus.base_empty
                 & ~bus.img_empty
                 & (~r_stage_valid | ~bus.out_full);

    // The staged byte leaves whenever the output FIFO can take it
    assign w_write = r_stage_valid & ~bus.out_full;

    assign w_count_nxt = r_count + 1'b1;

    // Both FIFOs share one pop strobe so base/image pixels can never slip
    assign bus.base_rd_en = w_pop;
    assign bus.img_rd_en  = w_pop;
    assign bus.out_wr_en  = w_write;
    assign bus.out_din    = r_stage;
    assign bus.busy       = r_busy;
    assign bus.done       = r_done;

    // ------------------------------------------------------------------------
    // Stage register: load on pop, empty on a write that has no pop behind it
    // ------------------------------------------------------------------------
    always_ff @(posedge clock) begin
        if (reset) begin
            r_stage_valid <= 1'b0;
            r_stage       <= 8'h00;
        end else if (w_pop) begin
            r_stage_valid <= 1'b1;
            r_stage       <= w_result;
        end else if (w_write) begin
            r_stage_valid <= 1'b0;
        end
    end

    // ------------------------------------------------------------------------
    // Frame sequencer with registered busy/done
    // ------------------------------------------------------------------------
    always_ff @(posedge clock) begin
        if (reset) begin
            r_state <= IDLE;
            r_count <= '0;
            r_busy  <= 1'b0;
            r_done  <= 1'b0;
        end else begin
            r_done <= 1'b0;
            case (r_state)
                IDLE: begin
                    if (bus.start) begin
                        r_state <= RUN;
                        r_count <= '0;
                        r_busy  <= 1'b1;
                    end
                end

                RUN: begin
                    if (w_pop) begin
                        r_count <= w_count_nxt;
                        // The last pixel of the frame has just been popped
                        if (w_count_nxt == c_last) begin
                            r_state <= DRAIN;
                        end
                    end
                end

                DRAIN: begin
                    // No pops here, so the stage empties on its final write;
                    // DONE follows in the very next cycle.
                    if (w_write || !r_stage_valid) begin
                        r_state <= DONE;
                        r_busy  <= 1'b0;
                        r_done  <= 1'b1;
                    end
                end

                DONE: begin
                    r_state <= IDLE;
                end

                default: begin
                    r_state <= IDLE;
                    r_busy  <= 1'b0;
                end
            endcase
        end
    end

endmodule : subtract_ctrl
`default_nettype wire

// File: tb/tb_subtract_ctrl.sv
`timescale 1ns/1ps
`default_nettype none
// ============================================================================
// Module      : tb_subtract_ctrl
// Description : Directed self-checking bench for subtract_ctrl on a 4x2 frame.
//               FWFT input FIFOs and the output side are modelled here.
//               Expected bytes are hand-computed tables; the mask variants
//               apply when SUBTRACT_THRESH_EN is defined.
// Revision    : 1.0 - initial release
// ============================================================================
module tb_subtract_ctrl;

    localparam int c_w = 4;
    localparam int c_h = 2;
    localparam int c_n = c_w * c_h;

    logic clock = 1'b0;
    logic reset;

    always #5 clock = ~clock;

    subtract_ctrl_if bus();

    subtract_ctrl #(
        .WIDTH    (c_w),
        .HEIGHT   (c_h),
        .THRESHOLD(50)
    ) dut (
        .clock(clock),
        .reset(reset),
        .bus  (bus)
    );

    // ------------------------------------------------------------------------
    // Stimulus frames and hand-computed results
    // ------------------------------------------------------------------------
    logic [7:0] f1_base [8] = '{8'd10, 8'd200, 8'd50, 8'd0,   8'd10, 8'd200, 8'd50, 8'd0};
    logic [7:0] f1_img  [8] = '{8'd30, 8'd100, 8'd50, 8'd255, 8'd30, 8'd100, 8'd50, 8'd255};
    logic [7:0] f2_base [8] = '{8'd255, 8'd0,   8'd128, 8'd127, 8'd1, 8'd2, 8'd3, 8'd100};
    logic [7:0] f2_img  [8] = '{8'd0,   8'd255, 8'd127, 8'd128, 8'd1, 8'd5, 8'd3, 8'd49};
`ifdef SUBTRACT_THRESH_EN
    logic [7:0] exp1 [8] = '{8'h00, 8'hFF, 8'h00, 8'hFF, 8'h00, 8'hFF, 8'h00, 8'hFF};
    logic [7:0] exp2 [8] = '{8'hFF, 8'hFF, 8'h00, 8'h00, 8'h00, 8'h00, 8'h00, 8'hFF};
`else
    logic [7:0] exp1 [8] = '{8'd20, 8'd100, 8'd0, 8'd255, 8'd20, 8'd100, 8'd0, 8'd255};
    logic [7:0] exp2 [8] = '{8'd255, 8'd255, 8'd1, 8'd1, 8'd0, 8'd3, 8'd0, 8'd51};
`endif

    // ------------------------------------------------------------------------
    // FWFT FIFO models
    // ------------------------------------------------------------------------
    logic [7:0] base_mem [16];
    logic [7:0] img_mem  [16];
    int         base_cnt = 0;
    int         img_cnt  = 0;
    int         base_ptr = 0;
    int         img_ptr  = 0;
    logic       img_block = 1'b0;
    logic       fifo_load = 1'b0;

    always @(posedge clock) begin
        if (fifo_load) begin
            base_ptr <= 0;
            img_ptr  <= 0;
        end else begin
            if (bus.base_rd_en) base_ptr <= base_ptr + 1;
            if (bus.img_rd_en)  img_ptr  <= img_ptr + 1;
        end
    end

    assign bus.base_empty = (base_ptr >= base_cnt);
    assign bus.base_dout  = base_mem[base_ptr[3:0]];
    assign bus.img_empty  = img_block | (img_ptr >= img_cnt);
    assign bus.img_dout   = img_mem[img_ptr[3:0]];

    // ------------------------------------------------------------------------
    // Output monitor, sampled mid-low-phase
    // ------------------------------------------------------------------------
    int         cyc = 0;
    int         nwr = 0;
    int         ndone = 0;
    int         first_pop_cyc = -1;
    int         first_wr_cyc = -1;
    int         last_wr_cyc = -1;
    int         done_cyc = -1;
    logic [7:0] wr_q [$];
    logic       mon_clr = 1'b1;

    always begin
        @(negedge clock);
        #2;
        cyc++;
        if (mon_clr) begin
            nwr = 0;
            ndone = 0;
            first_pop_cyc = -1;
            first_wr_cyc = -1;
            last_wr_cyc = -1;
            done_cyc = -1;
            wr_q.delete();
        end else begin
            if (bus.base_rd_en && first_pop_cyc < 0) first_pop_cyc = cyc;
            if (bus.out_wr_en) begin
                if (first_wr_cyc < 0) first_wr_cyc = cyc;
                last_wr_cyc = cyc;
                nwr++;
                wr_q.push_back(bus.out_din);
            end
            if (bus.done) begin
                ndone++;
                done_cyc = cyc;
            end
        end
    end

    // ------------------------------------------------------------------------
    // Checking
    // ------------------------------------------------------------------------
    int n_chk  = 0;
    int n_fail = 0;

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_chk++;
        if (obs !== exp) begin
            n_fail++;
            $display("FAIL %s: observed %0d (0x%0h), expected %0d (0x%0h)", tag, obs, obs, exp, exp);
        end
    endtask

    task automatic load_frame(input logic [7:0] b [8], input logic [7:0] im [8]);
        for (int i = 0; i < 8; i++) begin
            base_mem[i] = b[i];
            img_mem[i]  = im[i];
        end
        base_cnt  = c_n;
        img_cnt   = c_n;
        fifo_load = 1'b1;
        mon_clr   = 1'b1;
        @(negedge clock);
        fifo_load = 1'b0;
        mon_clr   = 1'b0;
    endtask

    task automatic pulse_start();
        bus.start = 1'b1;
        @(negedge clock);
        bus.start = 1'b0;
    endtask

    task automatic wait_done(input string tag);
        for (int i = 0; i < 100 && ndone == 0; i++) @(negedge clock);
        chk({tag, "_done_seen"}, 32'(ndone != 0), 32'd1);
        repeat (3) @(negedge clock);
    endtask

    task automatic check_frame(input string tag, input logic [7:0] e [8]);
        chk({tag, "_writes"}, 32'(nwr), 32'(c_n));
        for (int i = 0; i < c_n; i++) begin
            chk($sformatf("%s_px%0d", tag, i),
                (i < wr_q.size()) ? 32'(wr_q[i]) : 32'hFFFF_FFFF, 32'(e[i]));
        end
        chk({tag, "_done_pulses"}, 32'(ndone), 32'd1);
        chk({tag, "_done_after_last_wr"}, 32'(done_cyc), 32'(last_wr_cyc + 1));
    endtask

    task automatic check_idle_outputs(input string tag);
        chk({tag, "_base_rd_en"}, 32'(bus.base_rd_en), 32'd0);
        chk({tag, "_img_rd_en"},  32'(bus.img_rd_en),  32'd0);
        chk({tag, "_out_wr_en"},  32'(bus.out_wr_en),  32'd0);
        chk({tag, "_out_din"},    32'(bus.out_din),    32'd0);
        chk({tag, "_busy"},       32'(bus.busy),       32'd0);
        chk({tag, "_done"},       32'(bus.done),       32'd0);
    endtask

    // Hard stop in case a wait escapes its bound
    initial begin
        #200000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    // ------------------------------------------------------------------------
    // Directed sequence
    // ------------------------------------------------------------------------
    initial begin
        reset        = 1'b1;
        bus.start    = 1'b0;
        bus.out_full = 1'b0;

        // Reset state
        repeat (3) @(negedge clock);
        #1;
        check_idle_outputs("reset");
        @(negedge clock);
        reset = 1'b0;

        // Nominal frame: latency, throughput, values, done timing
        load_frame(f1_base, f1_img);
        pulse_start();
        chk("f1_busy_in_run", 32'(bus.busy), 32'd1);
        wait_done("f1");
        check_frame("f1", exp1);
        chk("f1_latency", 32'(first_wr_cyc), 32'(first_pop_cyc + 1));
        chk("f1_throughput", 32'(last_wr_cyc - first_wr_cyc), 32'(c_n - 1));
        chk("f1_busy_after", 32'(bus.busy), 32'd0);

        // Image FIFO empty: no pops, no writes, then the full frame completes
        load_frame(f1_base, f1_img);
        img_block = 1'b1;
        pulse_start();
        for (int i = 0; i < 5; i++) begin
            chk($sformatf("starve_base_rd_c%0d", i), 32'(bus.base_rd_en), 32'd0);
            chk($sformatf("starve_wr_c%0d", i),      32'(bus.out_wr_en),  32'd0);
            @(negedge clock);
        end
        chk("starve_no_writes", 32'(nwr), 32'd0);
        img_block = 1'b0;
        wait_done("starve");
        check_frame("starve", exp1);

        // Output back-pressure for 3 cycles with a staged byte
        load_frame(f2_base, f2_img);
        pulse_start();
        for (int i = 0; i < 20 && !bus.out_wr_en; i++) @(negedge clock);
        bus.out_full = 1'b1;
        for (int i = 0; i < 3; i++) begin
            #1;
            chk($sformatf("stall_pop_c%0d", i),   32'(bus.base_rd_en), 32'd0);
            chk($sformatf("stall_wr_c%0d", i),    32'(bus.out_wr_en),  32'd0);
            chk($sformatf("stall_stage_c%0d", i), 32'(bus.out_din),    32'(exp2[0]));
            @(negedge clock);
        end
        bus.out_full = 1'b0;
        for (int i = 0; i < 4; i++) begin
            #1;
            chk($sformatf("resume_wr_c%0d", i), 32'(bus.out_wr_en), 32'd1);
            @(negedge clock);
        end
        wait_done("stall");
        check_frame("stall", exp2);

        // Reset after 3 of 8 pixels aborts the frame
        load_frame(f1_base, f1_img);
        pulse_start();
        for (int i = 0; i < 30 && base_ptr != 3; i++) @(negedge clock);
        chk("abort_reached_3", 32'(base_ptr), 32'd3);
        reset = 1'b1;
        @(negedge clock);
        #1;
        check_idle_outputs("abort");
        reset = 1'b0;

        // Reset wins over a simultaneous start
        load_frame(f2_base, f2_img);
        reset     = 1'b1;
        bus.start = 1'b1;
        @(negedge clock);
        reset     = 1'b0;
        bus.start = 1'b0;
        @(negedge clock);
        #1;
        chk("prio_busy", 32'(bus.busy), 32'd0);
        chk("prio_pop",  32'(bus.base_rd_en), 32'd0);

        // A fresh start after the abort runs a complete frame
        load_frame(f2_base, f2_img);
        pulse_start();
        wait_done("restart");
        check_frame("restart", exp2);

        // A second start during RUN is ignored
        load_frame(f1_base, f1_img);
        pulse_start();
        @(negedge clock);
        pulse_start();
        wait_done("restart_ign");
        check_frame("restart_ign", exp1);
        repeat (4) @(negedge clock);
        chk("restart_ign_single_done", 32'(ndone), 32'd1);
        chk("restart_ign_idle_busy", 32'(bus.busy), 32'd0);

        $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
        $finish;
    end

endmodule : tb_subtract_ctrl
`default_nettype wire
